// File: rtl/move_cmd_gen.sv
// Turns four raw player push-buttons into single-cycle n/s/e/w move pulses for the room FSM,
// with synchronisation, debounce, ambiguity rejection, release gating and game-over lockout.
module move_cmd_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned MOVE_W          = 8
) (
   input  logic              clock,
   input  logic              R,
   input  logic              btn_n,
   input  logic              btn_s,
   input  logic              btn_e,
   input  logic              btn_w,
   input  logic              game_over,
   output logic              n,
   output logic              s,
   output logic              e,
   output logic              w,
   output logic              busy,
   output logic [MOVE_W-1:0] moves
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE    = 2'd1,
      WAIT_REL = 2'd2,
      LOCKED   = 2'd3
   } state_t;

   // Bit order everywhere: {n, s, e, w}
   logic [3:0]            raw;
   logic [3:0]            sync1;
   logic [3:0]            sync2;
   logic [3:0]            db;
   logic [3:0][CNT_W-1:0] cnt;
   logic                  any_press;
   logic                  single_press;

   state_t              state;
   state_t              state_nxt;
   logic [3:0]          dir_nxt;
   logic [MOVE_W-1:0]   moves_nxt;

   assign raw = {btn_n, btn_s, btn_e, btn_w};

   // Two-flop synchroniser for the asynchronous buttons
   always_ff @(posedge clock or posedge R) begin
      if (R) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Debounce: a level change must persist DEBOUNCE_CYCLES consecutive cycles; any bounce restarts it
   always_ff @(posedge clock or posedge R) begin
      if (R) begin
         db  <= '0;
         cnt <= '0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (sync2[b] == db[b]) begin
               cnt[b] <= '0;
            end else if (cnt[b] == CNT_LAST) begin
               db[b]  <= sync2[b];
               cnt[b] <= '0;
            end else begin
               cnt[b] <= cnt[b] + CNT_W'(1);
            end
         end
      end
   end

   assign any_press    = |db;
   assign single_press = any_press && ((db & (db - 4'd1)) == 4'd0);

   // Move FSM: next state, next pulse vector and next move count
   always_comb begin
      state_nxt = state;
      dir_nxt   = '0;
      moves_nxt = moves;
      case (state)
         IDLE: begin
            if (game_over) begin
               state_nxt = LOCKED;
            end else if (single_press) begin
               state_nxt = PULSE;
               dir_nxt   = db;
               if (moves != '1) begin
                  moves_nxt = moves + MOVE_W'(1);
               end
            end else if (any_press) begin
               state_nxt = WAIT_REL;
            end
         end
         PULSE: begin
            state_nxt = game_over ? LOCKED : WAIT_REL;
         end
         WAIT_REL: begin
            if (game_over) begin
               state_nxt = LOCKED;
            end else if (!any_press) begin
               state_nxt = IDLE;
            end
         end
         LOCKED: begin
            state_nxt = LOCKED;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered state and outputs; reset cuts off any pulse in flight
   always_ff @(posedge clock or posedge R) begin
      if (R) begin
         state        <= IDLE;
         {n, s, e, w} <= 4'b0000;
         busy         <= 1'b0;
         moves        <= '0;
      end else begin
         state        <= state_nxt;
         {n, s, e, w} <= dir_nxt;
         busy         <= (state_nxt != IDLE);
         moves        <= moves_nxt;
      end
   end

endmodule
